out_fifo_ctrl: RTL
==================

Name: out_fifo_ctrl

Overview:
- Output-FIFO controller for the conv accelerator's result stream.
- Wraps a DEPTH-entry dual-port RAM with a 1-cycle registered read and write-through on same-address collision.
- Manages pointers, occupancy and a valid/ready handshake on both sides.
- Sits between the MAC/output stage (producer) and the accelerator's output port (consumer).

Parameters:
- OUTW, 16: data width in bits.
- DEPTH, 8: capacity in words; power of two, minimum 2.
- AF_THRESH, 6: almost-full threshold (used only with the optional feature); 1 <= AF_THRESH <= DEPTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as reset on the controller state.
- in_data  in  OUTW  producer data.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  OUTW  head-of-FIFO data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word.
- count  out  $clog2(DEPTH+1)  words accepted but not yet popped.

Behaviour:
- Push: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Reset/clear:
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1 in the cycle after the edge.
  - RAM contents are not cleared.
  - reset asserted mid-stream discards all words; a push or pop in that same cycle is ignored.
- in_ready = (count < DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- When full: in_ready=0 even if a pop occurs that cycle; in_ready returns high the cycle after the pop.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle. Never exceeds DEPTH, never underflows.
- Pointers: log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0. Full/empty is decided by count, not pointer compare.
- Write: RAM wr_en = push, write_addr = wr_ptr, data = in_data. wr_ptr increments on push.
- Read latency:
  - Word pushed in cycle n into an empty FIFO gives out_valid=1 with that word in cycle n+2.
  - Data is never presented in cycle n+1.
  - The write-through collision path must be handled; the head word must be correct when the read address equals the write address.
- Head register/prefetch:
  - Controller keeps the RAM read address on the head entry. A read is "issued" when the RAM holds an un-presented word and the head slot is empty or being popped.
  - out_valid goes high the cycle after the issue and stays high until popped.
- Hold rule: while out_valid && !out_ready, out_data and out_valid are stable. A push in that cycle must not disturb out_data, including wrap-around to the head address when count=DEPTH-1.
- Throughput: with count >= 2 and both sides always ready, one push and one pop every cycle with no bubbles. A pop of the last word with a same-cycle push into an empty RAM follows the 2-cycle latency rule (one bubble allowed).
- Order: strict FIFO. Every pushed word is popped exactly once unless discarded by reset/clear.
- out_data when out_valid=0: don't-care.

Optional Feature:
- Macro: OUT_FIFO_ALMOST_FULL_EN.
- Defined:
  - Extra output port almost_full (1 bit), registered, = (count >= AF_THRESH) evaluated on the next-state count.
  - Reset/clear value 0.
  - The producer uses it for early back-pressure.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (DEPTH=8, OUTW=16):
- Single word: reset, push 0x00A5 in cycle 3, out_ready=1 -> out_valid=0 in cycle 4, out_valid=1/out_data=0x00A5 in cycle 5, popped; count 0->1->0.
- Fill to full: out_ready=0, push 0x0001..0x0009 continuously -> words 1..8 accepted; in_ready=0 after the 8th; count=8; word 9 held by producer; out_data stays 0x0001 throughout.
- Wrap and streaming:
  - 20 words 0x0100..0x0113, both sides always ready -> popped in order.
  - After the initial 2-cycle latency, out_valid is continuous while count >= 2.
  - Pointers wrap twice with no loss or duplication.
- Simultaneous push/pop at full: count=8, in_valid=1, out_ready=1 -> pop only, count=7; next cycle push and pop together leave count=7.
- Reset mid-op: count=5 with a push and pop in the same cycle as reset=1 -> next cycle count=0, out_valid=0, in_ready=1; a subsequent push of 0xBEEF emerges first. Repeat with clear instead of reset for the same result.
- With OUT_FIFO_ALMOST_FULL_EN, AF_THRESH=6: push 6 with no pops -> almost_full=1 once count=6; one pop -> almost_full=0 when count=5.

Source files
------------

// File: rtl/out_fifo_ctrl_if.sv
// Stream bundle for the output FIFO: producer push side, consumer pop side, occupancy.
// The almost_full signal exists only when OUT_FIFO_ALMOST_FULL_EN is defined.
interface out_fifo_ctrl_if #(
  parameter int OUTW  = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [OUTW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [OUTW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   count;
`ifdef OUT_FIFO_ALMOST_FULL_EN
  logic            almost_full;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid,
    output count, almost_full
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid,
    input  count, almost_full
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid,
    output count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid,
    input  count
  );
`endif
endinterface

// File: rtl/out_fifo_ctrl.sv
// Output FIFO controller: DEPTH-entry RAM, 1-cycle registered read, head prefetch.
// Optional almost_full output enabled by defining OUT_FIFO_ALMOST_FULL_EN.
module out_fifo_ctrl #(
  parameter int OUTW      = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  out_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_param
    $error("out_fifo_ctrl: illegal DEPTH or AF_THRESH");
  end

  logic [OUTW-1:0] mem_q [DEPTH];
  logic [OUTW-1:0] rdata_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   pend;
  logic            flush;
  logic            in_ready;
  logic            push, pop, issue;
  logic            wr_en, rd_en;

  always_comb begin
    flush    = reset || clear;
    in_ready = count_q < FULL;
    push     = bus.in_valid && in_ready;
    pop      = out_valid_q && bus.out_ready;
    // words in RAM not yet moved to the head register
    pend     = count_q - CW'(out_valid_q);
    issue    = (pend != '0) && (!out_valid_q || pop);
    wr_en    = push && !flush;
    rd_en    = issue && !flush;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (issue)    out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.in_data;
  end

  // head register only loads on issue, so a held word survives any push
  always_ff @(posedge clk) begin
    if (rd_en) begin
      if (wr_en && wr_ptr_q == rd_ptr_q) rdata_q <= bus.in_data;
      else                               rdata_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rdata_q;
  assign bus.count     = count_q;

`ifdef OUT_FIFO_ALMOST_FULL_EN
  localparam logic [CW-1:0] AF_LVL = CW'(AF_THRESH);
  logic almost_full_q;

  always_ff @(posedge clk) begin
    if (flush) almost_full_q <= 1'b0;
    else       almost_full_q <= count_d >= AF_LVL;
  end

  assign bus.almost_full = almost_full_q;
`endif
endmodule
